// File: rtl/temp_log_sequencer.sv
// Die-temperature logging controller: conditions channel-17 ADC samples and sequences
// FIFO fill/drain, clear and occupancy tracking. All outputs are registered.
module temp_log_sequencer #(
    parameter logic [4:0]  ADC_CHANNEL = 5'd17,
    parameter logic [11:0] OFFSET      = 12'd3431,
    parameter int unsigned FILL_COUNT  = 30
) (
    input  logic        clock_in,
    input  logic        reset,
    input  logic        sample_tick,
    input  logic        adc_valid,
    input  logic [4:0]  adc_channel,
    input  logic [11:0] adc_data,
    input  logic        step_n,
    input  logic        clear_req,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    output logic [8:0]  fifo_data,
    output logic        fifo_rdreq,
    output logic        fifo_sclr,
    output logic [4:0]  occ_count,
    output logic        mode_drain,
    output logic        write_blip
);
    typedef enum logic [1:0] {FLUSH, FILL, DRAIN} state_t;

    localparam logic [4:0] FILL_LAST = 5'(FILL_COUNT);

    state_t      state;
    logic [11:0] sample_diff;
    logic [8:0]  sample_cond;
    logic [8:0]  sample_reg;
    logic        sample_seen;
    logic        s1, s2, s3;
    logic        press;

    always_comb begin
        sample_diff = adc_data - OFFSET;
        if (adc_data < OFFSET)
            sample_cond = '0;
        else if (sample_diff > 12'd511)
            sample_cond = '1;
        else
            sample_cond = sample_diff[8:0];
    end

    // Falling edge of the synchronised active-low button
    assign press = s3 & ~s2;

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sample_reg  <= '0;
            sample_seen <= 1'b0;
            s1          <= 1'b1;
            s2          <= 1'b1;
            s3          <= 1'b1;
        end else begin
            if (adc_valid && adc_channel == ADC_CHANNEL) begin
                sample_reg  <= sample_cond;
                sample_seen <= 1'b1;
            end
            s1 <= step_n;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // fifo_sclr is asserted exactly while the state register holds FLUSH
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state      <= FLUSH;
            fifo_sclr  <= 1'b1;
            fifo_wrreq <= 1'b0;
            fifo_rdreq <= 1'b0;
            fifo_data  <= '0;
            occ_count  <= '0;
            mode_drain <= 1'b0;
            write_blip <= 1'b0;
        end else begin
            fifo_wrreq <= 1'b0;
            fifo_rdreq <= 1'b0;
            fifo_sclr  <= 1'b0;
            if (clear_req) begin
                state      <= FLUSH;
                fifo_sclr  <= 1'b1;
                mode_drain <= 1'b0;
            end else begin
                case (state)
                    FLUSH: begin
                        occ_count <= '0;
                        state     <= FILL;
                    end
                    FILL: begin
                        if (sample_tick && sample_seen && !fifo_full && occ_count < FILL_LAST) begin
                            fifo_wrreq <= 1'b1;
                            fifo_data  <= sample_reg;
                            occ_count  <= occ_count + 5'd1;
                            write_blip <= ~write_blip;
                            if (occ_count == FILL_LAST - 5'd1) begin
                                state      <= DRAIN;
                                mode_drain <= 1'b1;
                            end
                        end
                    end
                    DRAIN: begin
                        if (press) begin
                            if (!fifo_empty && occ_count != '0) begin
                                fifo_rdreq <= 1'b1;
                                occ_count  <= occ_count - 5'd1;
                                if (occ_count == 5'd1) begin
                                    state      <= FILL;
                                    mode_drain <= 1'b0;
                                end
                            end else begin
                                state      <= FILL;
                                mode_drain <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state      <= FLUSH;
                        fifo_sclr  <= 1'b1;
                        mode_drain <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_temp_log_sequencer.sv
// Directed bench for temp_log_sequencer: write data checked through a scoreboard queue,
// read pulses counted by a monitor, FIFO occupancy flags supplied by a small model.
module tb_temp_log_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic        adc_valid;
    logic [4:0]  adc_channel;
    logic [11:0] adc_data;
    logic        step_n;
    logic        clear_req;
    logic        fifo_empty;
    logic        fifo_full;
    logic        fifo_wrreq;
    logic [8:0]  fifo_data;
    logic        fifo_rdreq;
    logic        fifo_sclr;
    logic [4:0]  occ_count;
    logic        mode_drain;
    logic        write_blip;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rd_pulses = 0;
    logic        rd_prev = 1'b0;
    logic [8:0]  exp_q[$];
    int          exp_occ = 0;
    logic        exp_blip = 1'b0;
    int          mcnt = 0;

    always #5 clk = ~clk;

    temp_log_sequencer #(
        .ADC_CHANNEL(5'd17),
        .OFFSET     (12'd3431),
        .FILL_COUNT (30)
    ) dut (
        .clock_in   (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .adc_valid  (adc_valid),
        .adc_channel(adc_channel),
        .adc_data   (adc_data),
        .step_n     (step_n),
        .clear_req  (clear_req),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_wrreq (fifo_wrreq),
        .fifo_data  (fifo_data),
        .fifo_rdreq (fifo_rdreq),
        .fifo_sclr  (fifo_sclr),
        .occ_count  (occ_count),
        .mode_drain (mode_drain),
        .write_blip (write_blip)
    );

    // 32-deep FIFO occupancy model driving the flags
    always @(posedge clk) begin
        if (reset || fifo_sclr)
            mcnt <= 0;
        else
            mcnt <= mcnt + (fifo_wrreq ? 1 : 0) - (fifo_rdreq ? 1 : 0);
    end
    assign fifo_empty = (mcnt == 0);
    assign fifo_full  = (mcnt >= 32);

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        n_checks++;
        assert (obs === 32'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_wrreq) begin
                check("wr_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("wr_data", 32'(fifo_data), int'(exp_q.pop_front()));
            end
            if (fifo_rdreq) begin
                rd_pulses++;
                check("wr_rd_excl", 32'(fifo_wrreq), 0);
                check("rd_width", 32'(rd_prev), 0);
            end
            rd_prev = fifo_rdreq;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic adc(input logic [4:0] ch, input logic [11:0] d);
        adc_valid   = 1'b1;
        adc_channel = ch;
        adc_data    = d;
        step();
        adc_valid   = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] ch, input logic [11:0] d, input logic [8:0] exp);
        adc(ch, d);
        exp_q.push_back(exp);
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        exp_occ++;
        exp_blip = ~exp_blip;
        check("wrreq", 32'(fifo_wrreq), 1);
        check("occ_wr", 32'(occ_count), exp_occ);
        check("blip", 32'(write_blip), int'(exp_blip));
        step();
    endtask

    task automatic press(input int hold, input int gap);
        step_n = 1'b0;
        repeat (hold) step();
        step_n = 1'b1;
        repeat (gap) step();
    endtask

    initial begin
        reset = 1'b1; sample_tick = 1'b0; adc_valid = 1'b0; adc_channel = '0;
        adc_data = '0; step_n = 1'b1; clear_req = 1'b0;
        repeat (3) step();
        check("rst_wrreq", 32'(fifo_wrreq), 0);
        check("rst_rdreq", 32'(fifo_rdreq), 0);
        check("rst_occ", 32'(occ_count), 0);
        check("rst_data", 32'(fifo_data), 0);
        check("rst_blip", 32'(write_blip), 0);
        check("rst_mode", 32'(mode_drain), 0);
        reset = 1'b0;
        check("sclr_first", 32'(fifo_sclr), 1);
        step();
        check("sclr_drop", 32'(fifo_sclr), 0);

        // Tick before any sample is dropped
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("no_sample_wr", 32'(fifo_wrreq), 0);
        check("no_sample_occ", 32'(occ_count), 0);
        step();

        do_write(5'd17, 12'd3500, 9'd69);
        do_write(5'd17, 12'd3000, 9'd0);
        do_write(5'd17, 12'd4095, 9'd511);
        adc(5'd17, 12'd3450);
        do_write(5'd5, 12'd4000, 9'd19);

        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("clr_sclr", 32'(fifo_sclr), 1);
        step();
        check("clr_sclr_drop", 32'(fifo_sclr), 0);
        check("clr_occ", 32'(occ_count), 0);
        exp_occ = 0;

        for (int i = 0; i < 30; i++) begin
            do_write(5'd17, 12'(3431 + i * 10), 9'(i * 10));
            check("fill_mode", 32'(mode_drain), (i == 29) ? 1 : 0);
        end
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        check("tick31_wr", 32'(fifo_wrreq), 0);
        check("tick31_occ", 32'(occ_count), 30);
        step();

        // First press: rdreq follows the third edge sampling step_n low
        step_n = 1'b0;
        step();
        step();
        check("press_lat2", 32'(fifo_rdreq), 0);
        step();
        check("press_lat3", 32'(fifo_rdreq), 1);
        step();
        check("press_one", 32'(fifo_rdreq), 0);
        repeat (96) step();
        step_n = 1'b1;
        repeat (5) step();
        check("drain_occ", 32'(occ_count), 29);
        for (int k = 1; k < 30; k++) begin
            press(100, 5);
            check("drain_occ", 32'(occ_count), 29 - k);
            check("drain_mode", 32'(mode_drain), (k == 29) ? 0 : 1);
        end
        check("rd_pulses", 32'(rd_pulses), 30);

        press(10, 5);
        check("fill_press_ign", 32'(rd_pulses), 30);
        check("fill_press_occ", 32'(occ_count), 0);

        exp_occ = 0;
        for (int i = 0; i < 12; i++) do_write(5'd17, 12'(3531 + i), 9'(100 + i));
        clear_req = 1'b1;
        sample_tick = 1'b1;
        step();
        clear_req = 1'b0;
        sample_tick = 1'b0;
        check("clr_tick_wr", 32'(fifo_wrreq), 0);
        check("clr_tick_sclr", 32'(fifo_sclr), 1);
        step();
        check("clr_tick_occ", 32'(occ_count), 0);
        check("clr_tick_mode", 32'(mode_drain), 0);
        exp_occ = 0;
        do_write(5'd17, 12'd3436, 9'd5);

        repeat (3) step();
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
